// File: rtl/gearbox_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_pkg
// Shared constants and types for the 64b/66b TX sequencing path.
//   SYNC_DATA / SYNC_CTRL : 2-bit sync header values
//   IDLE_BLOCK            : control block payload of block type 0x1E with all
//                           idle codes zero (type byte in the low byte)
//   gb_block_t            : encoded block {hdr, data} as carried in the buffer
// -----------------------------------------------------------------------------
package gearbox_pkg;

  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [1:0]  SYNC_CTRL  = 2'b10;
  localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;
  localparam int          BLOCK_W    = 66;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } gb_block_t;

endpackage

// File: rtl/gearbox_tx_fifo.sv
// -----------------------------------------------------------------------------
// gearbox_tx_fifo
// Synchronous block buffer with a first-word-fall-through head.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_wr_en/i_wr_data: write strobe and entry (caller guarantees !o_full)
//   i_rd_en          : pop strobe (caller guarantees !o_empty)
//   o_rd_data        : current head entry, valid whenever !o_empty
//   o_full/o_empty   : occupancy flags
// A written entry becomes poppable one cycle after the write edge: the empty
// flag compares against a registered copy of the write pointer. The full flag
// uses the live write pointer so the upstream ready drops immediately.
// -----------------------------------------------------------------------------
module gearbox_tx_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_wptr_vis;
  logic [AW:0]      r_rptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr     <= '0;
      r_wptr_vis <= '0;
      r_rptr     <= '0;
    end else begin
      r_wptr_vis <= r_wptr;
      if (i_wr_en) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_rd_en) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rptr[AW-1:0]];
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_rptr == r_wptr_vis);

endmodule

// File: rtl/gearbox_tx_ctrl.sv
// -----------------------------------------------------------------------------
// gearbox_tx_ctrl
// Sequencer between the 64b/66b encoder and the TX gearbox. Buffers whole
// blocks, emits each as two words (low half first) and fills gaps with idle
// control blocks so the gearbox always sees a continuous stream.
//   i_clk, i_reset_n   : clock, asynchronous active-low reset
//   i_tx_en            : when low, only idle blocks are started
//   i_block_data/_hdr  : encoded block from the encoder
//   i_block_valid      : block present; accepted when o_block_ready is high
//   o_block_ready      : buffer not full
//   o_data/o_hdr       : word and sync header to the gearbox
//   o_data_valid       : word strobe to the gearbox
//   i_gearbox_pause    : gearbox back-pressure; freezes the sequencer
//   o_idle_cnt         : idle blocks inserted (saturating)
//   o_block_cnt        : buffered blocks sent (saturating)
// -----------------------------------------------------------------------------
module gearbox_tx_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_tx_en,
  input  logic [2*DATA_WIDTH-1:0] i_block_data,
  input  logic [1:0]              i_block_hdr,
  input  logic                    i_block_valid,
  output logic                    o_block_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [1:0]              o_hdr,
  output logic                    o_data_valid,
  input  logic                    i_gearbox_pause,
  output logic [CNT_WIDTH-1:0]    o_idle_cnt,
  output logic [CNT_WIDTH-1:0]    o_block_cnt
);

  import gearbox_pkg::*;

  localparam int BLK_W   = 2 * DATA_WIDTH;
  localparam int ENTRY_W = BLK_W + 2;

  localparam logic [0:0] ST_H0 = 1'b0;
  localparam logic [0:0] ST_H1 = 1'b1;

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_upper;

  logic                  w_fifo_wr;
  logic                  w_fifo_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic [BLK_W-1:0]      w_sel_blk;
  logic [1:0]            w_sel_hdr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  gearbox_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data ({i_block_hdr, i_block_data}),
    .i_rd_en   (w_fifo_pop),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign o_block_ready = !w_fifo_full;
  assign w_fifo_wr     = i_block_valid && !w_fifo_full;

  // A block is only started in H0; i_tx_en is ignored in H1 so a block that
  // has begun always completes.
  assign w_fifo_pop = !i_gearbox_pause && (r_state == ST_H0) &&
                      i_tx_en && !w_fifo_empty;
  assign w_sel_blk  = w_fifo_pop ? w_head[BLK_W-1:0] : BLK_W'(IDLE_BLOCK);
  assign w_sel_hdr  = w_fifo_pop ? w_head[ENTRY_W-1 -: 2] : SYNC_CTRL;

  // Output stage: sequencer state, output word and counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_H0;
      o_data       <= '0;
      o_hdr        <= '0;
      o_data_valid <= 1'b0;
      o_idle_cnt   <= '0;
      o_block_cnt  <= '0;
    end else if (i_gearbox_pause) begin
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= 1'b1;
      case (r_state)
        ST_H0: begin
          o_data  <= w_sel_blk[DATA_WIDTH-1:0];
          o_hdr   <= w_sel_hdr;
          r_state <= ST_H1;
          if (w_fifo_pop) o_block_cnt <= sat_inc(o_block_cnt);
          else            o_idle_cnt  <= sat_inc(o_idle_cnt);
        end
        default: begin
          o_data  <= r_upper;
          r_state <= ST_H0;
        end
      endcase
    end
  end

  // Upper half of the block being sent; pure data, not reset.
  always_ff @(posedge i_clk) begin
    if (!i_gearbox_pause && (r_state == ST_H0)) r_upper <= w_sel_blk[BLK_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_gearbox_tx_ctrl.sv
module tb_gearbox_tx_ctrl;
  import gearbox_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_en;
  logic [63:0]   bdata;
  logic [1:0]    bhdr;
  logic          bvalid;
  logic          ready;
  logic [DW-1:0] odata;
  logic [1:0]    ohdr;
  logic          ovalid;
  logic          pause;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] block_cnt;

  gearbox_tx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_tx_en         (tx_en),
    .i_block_data    (bdata),
    .i_block_hdr     (bhdr),
    .i_block_valid   (bvalid),
    .o_block_ready   (ready),
    .o_data          (odata),
    .o_hdr           (ohdr),
    .o_data_valid    (ovalid),
    .i_gearbox_pause (pause),
    .o_idle_cnt      (idle_cnt),
    .o_block_cnt     (block_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: blocks accepted but not yet started, each stamped with
  // its acceptance edge; a block may start no earlier than two edges later.
  typedef struct {
    gb_block_t blk;
    int        t;
  } ent_t;

  ent_t        pend_q[$];
  int          t;
  int          n_idle, n_data;
  bit          have_low;
  logic [31:0] hi_w;
  logic [1:0]  low_hdr;
  int          n_chk, n_fail;

  function automatic int satc(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    n_idle   = 0;
    n_data   = 0;
    have_low = 0;
    t        = 0;
  endtask

  // One clock edge with full scoreboard checking of the resulting outputs.
  task automatic cyc();
    bit          wr, en, p, must;
    logic [31:0] od;
    logic [1:0]  oh;
    ent_t        e;
    gb_block_t   b;
    wr    = bvalid && (pend_q.size() < DEPTH);
    e.blk = {bhdr, bdata};
    en    = tx_en;
    p     = pause;
    od    = odata;
    oh    = ohdr;
    @(posedge clk);
    #1;
    t++;
    if (wr) begin
      e.t = t;
      pend_q.push_back(e);
    end
    if (p) begin
      chk("pause_valid", ovalid, 0);
      chk("pause_data", odata, od);
      chk("pause_hdr", ohdr, oh);
    end else begin
      chk("valid", ovalid, 1);
      if (have_low) begin
        chk("hi_data", odata, hi_w);
        chk("hi_hdr", ohdr, low_hdr);
        have_low = 0;
      end else begin
        must = en && (pend_q.size() > 0) && (pend_q[0].t + 2 <= t);
        if (must) begin
          e = pend_q.pop_front();
          b = e.blk;
          chk("lo_data", odata, b.data[31:0]);
          chk("lo_hdr", ohdr, b.hdr);
          hi_w    = b.data[63:32];
          low_hdr = b.hdr;
          n_data++;
        end else begin
          chk("idle_lo_data", odata, IDLE_BLOCK[31:0]);
          chk("idle_lo_hdr", ohdr, SYNC_CTRL);
          hi_w    = IDLE_BLOCK[63:32];
          low_hdr = SYNC_CTRL;
          n_idle++;
        end
        have_low = 1;
      end
    end
    chk("idle_cnt", idle_cnt, satc(n_idle));
    chk("block_cnt", block_cnt, satc(n_data));
    chk("ready", ready, pend_q.size() < DEPTH);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, odata, 0);
    chk({tag, "_hdr"}, ohdr, 0);
    chk({tag, "_valid"}, ovalid, 0);
    chk({tag, "_idle_cnt"}, idle_cnt, 0);
    chk({tag, "_block_cnt"}, block_cnt, 0);
    chk({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    int acc, cnt0, lim;
    logic [63:0] blocks [6];
    n_chk = 0;
    n_fail = 0;
    model_clear();
    rst_n = 1'b0; tx_en = 1'b1; bdata = '0; bhdr = SYNC_DATA; bvalid = 1'b0; pause = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle stream straight out of reset.
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("idle_alt", odata, (i % 2 == 0) ? 32'h0000_001E : 32'h0);
    end
    chk("idle_cnt_4", idle_cnt, 4);

    // Single data block written while in H0.
    bdata = 64'hDEADBEEF_01234567; bhdr = SYNC_DATA; bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    cyc();
    cyc();
    chk("blk1_lo", odata, 32'h01234567);
    chk("blk1_hdr", ohdr, 2'b01);
    cyc();
    chk("blk1_hi", odata, 32'hDEADBEEF);
    chk("blk1_cnt", block_cnt, 1);
    cyc();
    chk("idle_resume", odata, 32'h0000_001E);
    cyc();

    // One-cycle pause in the H1 of a data block.
    bdata = 64'hAAAA5555_11112222; bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    cyc();
    cyc();
    chk("p_lo", odata, 32'h11112222);
    pause = 1'b1;
    cyc();
    chk("p_hold_valid", ovalid, 0);
    chk("p_hold_data", odata, 32'h11112222);
    pause = 1'b0;
    cyc();
    chk("p_hi", odata, 32'hAAAA5555);
    chk("p_hi_valid", ovalid, 1);
    cyc();
    chk("p_after", odata, 32'h0000_001E);

    // Six back-to-back blocks against a 10-cycle pause.
    for (int i = 0; i < 6; i++) blocks[i] = {$urandom, $urandom};
    acc = 0;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bvalid = (acc < 6);
      bdata  = blocks[acc % 6];
      if (bvalid && pend_q.size() < DEPTH) begin
        cyc();
        acc++;
      end else cyc();
    end
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", ready, 0);
    pause = 1'b0;
    lim = 0;
    while (acc < 6 && lim < 50) begin
      bvalid = 1'b1;
      bdata  = blocks[acc];
      if (pend_q.size() < DEPTH) acc++;
      cyc();
      lim++;
    end
    bvalid = 1'b0;
    chk("bp_all_accepted", acc, 6);
    lim = 0;
    while (pend_q.size() > 0 && lim < 50) begin
      cyc();
      lim++;
    end
    chk("bp_drained", pend_q.size(), 0);
    cyc();
    cyc();

    // TX disabled with two blocks buffered.
    tx_en = 1'b0;
    cnt0 = n_data;
    for (int i = 0; i < 2; i++) begin
      bvalid = 1'b1; bdata = {$urandom, $urandom};
      cyc();
    end
    bvalid = 1'b0;
    repeat (8) cyc();
    chk("dis_block_cnt", block_cnt, satc(cnt0));
    chk("dis_retained", pend_q.size(), 2);
    tx_en = 1'b1;
    repeat (8) cyc();
    chk("en_block_cnt", block_cnt, satc(cnt0 + 2));
    chk("en_drained", pend_q.size(), 0);

    // Reset in the H1 of a data block with a second block still buffered.
    while (have_low) cyc();
    for (int i = 0; i < 2; i++) begin
      bvalid = 1'b1; bdata = {$urandom, $urandom};
      cyc();
    end
    bvalid = 1'b0;
    lim = 0;
    while (!(have_low && low_hdr == SYNC_DATA) && lim < 10) begin
      cyc();
      lim++;
    end
    chk("rst_in_h1_reached", have_low && low_hdr == SYNC_DATA, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(posedge clk);
    #1;
    check_zero("mid_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cyc();
    chk("post_rst_lo", odata, 32'h0000_001E);
    chk("post_rst_hdr", ohdr, SYNC_CTRL);
    repeat (6) cyc();

    // Randomized traffic, pause and enable against the model.
    for (int i = 0; i < 400; i++) begin
      bvalid = ($urandom_range(0, 99) < 60);
      bdata  = {$urandom, $urandom};
      bhdr   = SYNC_DATA;
      pause  = ($urandom_range(0, 99) < 20);
      tx_en  = ($urandom_range(0, 99) < 85);
      cyc();
    end
    bvalid = 1'b0; pause = 1'b0; tx_en = 1'b1;
    lim = 0;
    while (pend_q.size() > 0 && lim < 60) begin
      cyc();
      lim++;
    end
    chk("rand_drained", pend_q.size(), 0);
    chk("sat_block_cnt", block_cnt, CMAX);
    chk("sat_idle_cnt", idle_cnt, CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gearbox_tx_ctrl.md
Name: gearbox_tx_ctrl

Overview:
- Sequencer between the 64b/66b encoder and the TX gearbox.
- Accepts whole 66-bit blocks (64-bit payload + 2-bit sync header) through a small elastic buffer.
- Splits each block into two 32-bit words, low half first. Holds on gearbox pause.
- When no block is available or TX is disabled, inserts idle control blocks so the gearbox sees a continuous stream.

Parameters:
- DATA_WIDTH, 32, gearbox word width; block width is 2*DATA_WIDTH.
- FIFO_DEPTH, 4, block buffer depth in blocks; power of 2, minimum 2.
- CNT_WIDTH, 16, width of status counters.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_tx_en  in  1  TX enable; when low, only idle blocks are emitted.
- i_block_data  in  2*DATA_WIDTH  encoded block payload.
- i_block_hdr  in  2  sync header (2'b01 data, 2'b10 control).
- i_block_valid  in  1  block present.
- o_block_ready  out  1  buffer can accept a block.
- o_data  out  DATA_WIDTH  word to gearbox i_data.
- o_hdr  out  2  header to gearbox i_hdr; constant across both halves of a block.
- o_data_valid  out  1  to gearbox i_data_valid.
- i_gearbox_pause  in  1  from gearbox o_gearbox_pause.
- o_idle_cnt  out  CNT_WIDTH  idle blocks inserted; saturating.
- o_block_cnt  out  CNT_WIDTH  buffered blocks sent; saturating.

Behaviour:
- Reset values: o_data=0, o_hdr=0, o_data_valid=0, both counters=0, FIFO empty, state=H0. Reset applies immediately, mid-block included; a partially sent block is discarded.
- Upstream handshake:
  - o_block_ready = !fifo_full (combinational).
  - A write occurs when i_block_valid && o_block_ready.
  - A write into a full FIFO is impossible by construction.
- Simultaneous write and pop when full: ready is still low that cycle (no pass-through).
- FSM states H0 (send low half) and H1 (send high half). All outputs are registered.
- Pause, any state, i_gearbox_pause=1 at clock edge:
  - o_data_valid<=0; o_data and o_hdr hold; state holds.
  - No pop; counters hold.
- H0, not paused:
  - Select source. Source is the FIFO head if i_tx_en && !fifo_empty, else IDLE_BLOCK with hdr 2'b10.
  - o_data<=sel[31:0], o_hdr<=sel_hdr, o_data_valid<=1.
  - Upper register <= sel[63:32].
  - If the source is the FIFO: pop and increment o_block_cnt, else increment o_idle_cnt.
  - Go to H1.
- H1, not paused: o_data<=upper register, o_hdr holds, o_data_valid<=1, go to H0.
- Block-atomicity:
  - i_tx_en is sampled only in H0.
  - Deasserting it in H1 finishes the current block.
  - Buffered blocks are retained while disabled and sent after re-enable.
- Latency: a block written at edge N appears as the low half at the output after edge N+2, provided the FSM is in H0 and not paused. Best case 2 cycles, worst case 3 (H1 in progress), plus pause cycles.
- Counters saturate at all-ones; no wrap.
- Pause asserted for consecutive cycles: hold for the full duration; no word is dropped or duplicated.

Decomposition:
- Shared package gearbox_pkg gets:
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
  - IDLE_BLOCK=64'h0000_0000_0000_001E (block type 0x1E in the low byte, all idle codes 0).
  - A typedef for the 66-bit encoded block {hdr, data}.
- One sub-module: gearbox_tx_fifo.
  - Synchronous FIFO: 66-bit entries, FIFO_DEPTH deep, full/empty flags, first-word-fall-through head.
  - Same clock and asynchronous active-low reset.

Test Plan:
- Reset, i_tx_en=1, no input, no pause for 8 cycles -> o_data alternates 0000001E / 00000000, o_hdr=2'b10, o_data_valid=1 from the 1st post-reset edge; o_idle_cnt=4.
- One block 64'hDEADBEEF_01234567, hdr 01, written while the FSM is in H0 -> two cycles later o_data=01234567, then DEADBEEF, hdr 01; o_block_cnt=1; idles resume afterwards.
- Pause pulsed for 1 cycle while the FSM is in H1 of block 64'hAAAA5555_11112222 -> o_data_valid=0 for that cycle with o_data=11112222 held; the next valid word is AAAA5555; no duplicates.
- 6 back-to-back valid blocks with FIFO_DEPTH=4 and pause held for 10 cycles -> o_block_ready drops after 4 are accepted; all 6 are eventually output in order; the reference-model comparison matches.
- i_tx_en=0 with 2 blocks buffered -> only idle blocks go out and o_block_cnt is unchanged; after re-enable both blocks are sent in order starting at the next H0.
- Reset asserted in H1 of a data block -> outputs zero immediately; the FIFO is empty after release; the first post-reset output is the low half of an idle block.
